// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared constants, segment table and FSM states for the display driver
package seg7_scan_driver_pkg;
    localparam logic [3:0] SEL_OFF   = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;
endpackage

// File: rtl/seg7_scan_driver_hex.sv
// hex_to_seg7: combinational hex nibble to active-low {g,f,e,d,c,b,a} pattern
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_TAB[i_hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment driver with blanking gaps and frame-aligned updates
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dig_en,
    input  logic        load,
    output logic        load_pend,
    output logic [6:0]  di0,
    output logic [6:0]  di1,
    output logic [6:0]  di2,
    output logic [6:0]  di3,
    output logic [3:0]  sel,
    output logic        frame_tick
);
    state_t           r_state, w_state_nx;
    logic [1:0]       r_idx, w_idx_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [3:0]       r_sel, w_sel_nx;
    logic             w_boundary;
    logic [15:0]      r_stage_val, r_disp_val;
    logic [3:0]       r_stage_en, r_disp_en;
    logic             r_pend;
    logic [6:0]       r_di [4];
    logic [6:0]       w_seg [4];

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_dec
            hex_to_seg7 u_dec (.i_hex(r_disp_val[4*k +: 4]), .o_seg(w_seg[k]));
        end
    endgenerate

    // Next state: BLANK gap then ON slot per digit; sel only changes on transitions
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt + 1'b1;
        w_sel_nx   = r_sel;
        w_boundary = 1'b0;
        if (r_state == ST_BLANK) begin
            if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
                w_state_nx = ST_ON;
                w_cnt_nx   = '0;
                w_sel_nx   = r_disp_en[r_idx] ? ~(4'b0001 << r_idx) : SEL_OFF;
            end
        end else if (r_cnt == CNT_W'(SLOT_CYC - 1)) begin
            w_state_nx = ST_BLANK;
            w_cnt_nx   = '0;
            w_idx_nx   = r_idx + 2'd1;
            w_sel_nx   = SEL_OFF;
            w_boundary = (r_idx == 2'd3);
        end
    end

    // Scan state, shared counter and registered digit select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_sel   <= SEL_OFF;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_sel   <= w_sel_nx;
        end
    end

    // Staging captures every load; display takes the old staging only at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_val <= '0;
            r_stage_en  <= '0;
            r_disp_val  <= '0;
            r_disp_en   <= '0;
            r_pend      <= 1'b0;
        end else begin
            if (load) begin
                r_stage_val <= value;
                r_stage_en  <= dig_en;
            end
            if (w_boundary) begin
                r_disp_val <= r_stage_val;
                r_disp_en  <= r_stage_en;
            end
            r_pend <= load ? 1'b1 : (w_boundary ? 1'b0 : r_pend);
        end
    end

    // Registered segment outputs, blanked for disabled digits
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            r_di[i] <= (rst || !r_disp_en[i]) ? SEG_BLANK : w_seg[i];
    end

    assign sel        = r_sel;
    assign load_pend  = r_pend;
    assign frame_tick = w_boundary;
    assign di0        = r_di[0];
    assign di1        = r_di[1];
    assign di2        = r_di[2];
    assign di3        = r_di[3];
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed loads checked against a frame-arithmetic model
module tb_seg7_scan_driver;
    localparam int SLOT  = 4;
    localparam int BLANK = 2;
    localparam int PER   = SLOT + BLANK;
    localparam int FRAME = 4 * PER;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dig_en = '0;
    logic        load = 1'b0;
    logic        load_pend, frame_tick;
    logic [6:0]  di0, di1, di2, di3;
    logic [3:0]  sel;

    seg7_scan_driver #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .value(value), .dig_en(dig_en), .load(load),
        .load_pend(load_pend), .di0(di0), .di1(di1), .di2(di2), .di3(di3),
        .sel(sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [15:0] m_stage, m_disp;
    logic [3:0]  m_stage_en, m_disp_en;
    logic        m_pend;
    logic [6:0]  m_di [4];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        m_stage = '0; m_disp = '0; m_stage_en = '0; m_disp_en = '0; m_pend = 1'b0;
        for (int i = 0; i < 4; i++) m_di[i] = 7'h7F;
        cyc = 0;
    endtask

    // one cycle: check outputs mid-cycle, drive inputs, advance model across the next edge
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] e);
        int ph, d;
        logic [3:0] sel_exp;
        @(negedge clk);
        ph = cyc % FRAME;
        d  = ph / PER;
        sel_exp = 4'hF;
        if ((ph % PER) >= BLANK && m_disp_en[d]) sel_exp[d] = 1'b0;
        chk("sel", 16'(sel), 16'(sel_exp));
        chk("di0", 16'(di0), 16'(m_di[0]));
        chk("di1", 16'(di1), 16'(m_di[1]));
        chk("di2", 16'(di2), 16'(m_di[2]));
        chk("di3", 16'(di3), 16'(m_di[3]));
        chk("load_pend", 16'(load_pend), 16'(m_pend));
        chk("frame_tick", 16'(frame_tick), 16'(ph == FRAME - 1));
        rst = 1'b0; load = ld; value = v; dig_en = e;
        for (int i = 0; i < 4; i++) m_di[i] = m_disp_en[i] ? seg_ref[m_disp[4*i +: 4]] : 7'h7F;
        if (ph == FRAME - 1) begin
            m_disp = m_stage; m_disp_en = m_stage_en; m_pend = 1'b0;
        end
        if (ld) begin
            m_stage = v; m_stage_en = e; m_pend = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic rnd();
        step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        idle();
        step(1'b1, 16'h1234, 4'b1111);
        while (cyc < 50) idle();
        step(1'b1, 16'h0000, 4'b1111);
        step(1'b1, 16'hFFFF, 4'b1111);
        while (cyc < 71) idle();
        step(1'b1, 16'hABCD, 4'b0101);
        while (cyc < 124) idle();
        repeat (240) rnd();
        step(1'b1, 16'h9876, 4'b1111);
        while (cyc % FRAME != FRAME - 1) idle();
        while (cyc % FRAME != 15) idle();
        @(negedge clk);
        chk("sel_lit_before_rst", 16'(sel), 16'(4'b1011));
        rst = 1'b1; load = 1'b1; value = 16'h5555; dig_en = 4'hF;
        model_clear();
        repeat (60) rnd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
